// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache miss path and
// the D-cache miss/writeback path. One transaction at a time is carried
// through IDLE -> ISSUE (stall-retry) -> WAIT (fixed latency) -> DONE.
// D has priority over I. After STARVE_MAX consecutive D grants that left I
// waiting, I is granted next. Grant and stall statistics saturate.
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [15:0]      addr_i,
  output logic             done_i,
  output logic [15:0]      data_out_i,
  input  logic             req_d,
  input  logic             wr_d,
  input  logic [15:0]      addr_d,
  input  logic [15:0]      data_in_d,
  output logic             done_d,
  output logic [15:0]      data_out_d,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out,
  input  logic             mem_stall,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt_i,
  output logic [CNT_W-1:0] grant_cnt_d,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner_d;     // 1: transaction belongs to D, 0: to I
  logic             r_wr;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic [LAT_W-1:0] r_wait_cnt;
  logic [STV_W-1:0] r_starve_cnt;
  logic [15:0]      r_data_out_i;
  logic [15:0]      r_data_out_d;
  logic [CNT_W-1:0] r_grant_cnt_i;
  logic [CNT_W-1:0] r_grant_cnt_d;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_grant_d;
  logic w_grant_i;
  logic w_last_wait;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Arbitration: D wins unless a waiting I has been passed over STARVE_MAX times.
  always_comb begin
    w_grant_d   = req_d && !(req_i && (r_starve_cnt == STV_LIM));
    w_grant_i   = req_i && !w_grant_d;
    w_last_wait = (r_wait_cnt == LAT_W'(1));
  end

  // State register.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: w_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_d || w_grant_i) w_next = S_ISSUE;
      S_ISSUE: if (!mem_stall)             w_next = S_WAIT;
      S_WAIT:  if (w_last_wait)            w_next = S_DONE;
      S_DONE:                              w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  // Transaction capture, wait countdown, read-data return and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_d     <= 1'b0;
      r_wr          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wait_cnt    <= '0;
      r_starve_cnt  <= '0;
      r_data_out_i  <= '0;
      r_data_out_d  <= '0;
      r_grant_cnt_i <= '0;
      r_grant_cnt_d <= '0;
      r_stall_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_owner_d <= w_grant_d;
            r_addr    <= w_grant_d ? addr_d : addr_i;
            r_wr      <= w_grant_d && wr_d;
            r_wdata   <= w_grant_d ? data_in_d : '0;
          end
          if (w_grant_d) begin
            r_grant_cnt_d <= sat_inc(r_grant_cnt_d);
            if (!req_i)                       r_starve_cnt <= '0;
            else if (r_starve_cnt != STV_LIM) r_starve_cnt <= r_starve_cnt + STV_W'(1);
          end else if (w_grant_i) begin
            r_grant_cnt_i <= sat_inc(r_grant_cnt_i);
            r_starve_cnt  <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
          else           r_wait_cnt  <= LAT_LOAD;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - LAT_W'(1);
          // Memory data is valid only in the final WAIT cycle; writes return nothing.
          if (w_last_wait && !r_wr) begin
            if (r_owner_d) r_data_out_d <= mem_data_out;
            else           r_data_out_i <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and requester handshakes decode from the registered state only.
  always_comb begin
    mem_rd      = (r_state == S_ISSUE) && !r_wr;
    mem_wr      = (r_state == S_ISSUE) &&  r_wr;
    mem_addr    = (r_state == S_ISSUE) ? r_addr : '0;
    mem_data_in = ((r_state == S_ISSUE) && r_wr) ? r_wdata : '0;
    done_i      = (r_state == S_DONE) && !r_owner_d;
    done_d      = (r_state == S_DONE) &&  r_owner_d;
    busy        = (r_state != S_IDLE);
  end

  assign data_out_i  = r_data_out_i;
  assign data_out_d  = r_data_out_d;
  assign grant_cnt_i = r_grant_cnt_i;
  assign grant_cnt_d = r_grant_cnt_d;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single transactions plus hand-written
// multi-cycle sequences. Expected completions go into a scoreboard queue when
// a request is driven; a negedge monitor models the memory (stalls, fixed
// read latency) and pops/compares on every done pulse.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, req_d = 1'b0, wr_d = 1'b0;
  logic [15:0] addr_i = '0, addr_d = '0, data_in_d = '0;
  logic [15:0] mem_data_out = '0;
  logic        mem_stall = 1'b0;

  logic        done_i, done_d, mem_rd, mem_wr, busy;
  logic [15:0] data_out_i, data_out_d, mem_addr, mem_data_in;
  logic [15:0] grant_cnt_i, grant_cnt_d, stall_cnt;

  // Narrow-counter instance driven by the same stimulus; only its counters are checked.
  logic        s_done_i, s_done_d, s_mem_rd, s_mem_wr, s_busy;
  logic [15:0] s_data_out_i, s_data_out_d, s_mem_addr, s_mem_data_in;
  logic [3:0]  s_grant_cnt_i, s_grant_cnt_d, s_stall_cnt;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .addr_i(addr_i), .done_i(done_i), .data_out_i(data_out_i),
    .req_d(req_d), .wr_d(wr_d), .addr_d(addr_d), .data_in_d(data_in_d),
    .done_d(done_d), .data_out_d(data_out_d),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .busy(busy),
    .grant_cnt_i(grant_cnt_i), .grant_cnt_d(grant_cnt_d), .stall_cnt(stall_cnt)
  );

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .req_i(req_i), .addr_i(addr_i), .done_i(s_done_i), .data_out_i(s_data_out_i),
    .req_d(req_d), .wr_d(wr_d), .addr_d(addr_d), .data_in_d(data_in_d),
    .done_d(s_done_d), .data_out_d(s_data_out_d),
    .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_data_in(s_mem_data_in),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .busy(s_busy),
    .grant_cnt_i(s_grant_cnt_i), .grant_cnt_d(s_grant_cnt_d), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stalls;
    logic [15:0] exp_i;   // data_out_i after completion
    logic [15:0] exp_d;   // data_out_d after completion
  } vec_t;

  typedef struct {
    logic        owner_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stalls;
    logic [15:0] data;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  int   stall_left = 0;
  int   strobe_cycles = 0;
  bit   acc_valid = 1'b0;
  int   acc_cyc = 0;
  logic [15:0] acc_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0100: return 16'hCAFE;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  task automatic push(input logic od, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input int stalls,
                      input logic [15:0] data, input int done_cyc);
    exp_t e;
    e.owner_d = od; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.stalls = stalls; e.data = data; e.done_cyc = done_cyc;
    sb.push_back(e);
  endtask

  // Memory model and scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      mem_stall = 1'b0;
      if (mem_rd || mem_wr) begin
        if (stall_left > 0) begin
          mem_stall = 1'b1;
          stall_left--;
        end
        strobe_cycles++;
        if (!mem_stall) begin
          if (sb.size() == 0) fail_event("unexpected_issue");
          else begin
            check("issue_addr",   mem_addr, sb[0].addr);
            check("issue_wr",     mem_wr, sb[0].wr);
            check("issue_wdata",  mem_data_in, sb[0].wr ? sb[0].wdata : 16'h0);
            check("strobe_len",   strobe_cycles, sb[0].stalls + 1);
          end
          acc_valid     = 1'b1;
          acc_cyc       = cyc;
          acc_addr      = mem_addr;
          strobe_cycles = 0;
        end
      end else begin
        check("idle_bus", {mem_addr, mem_data_in}, 32'h0);
      end
      mem_data_out = (acc_valid && cyc == acc_cyc + MEM_LAT) ? mem_val(acc_addr)
                                                            : (16'hDEAD ^ 16'(cyc));
      check("rd_wr_excl",   mem_rd & mem_wr, 1'b0);
      check("done_excl",    done_i & done_d, 1'b0);
      if (done_i || done_d) begin
        if (sb.size() == 0) fail_event("unexpected_done");
        else begin
          exp_t e;
          e = sb.pop_front();
          check("done_owner", done_d, e.owner_d);
          check("done_cycle", cyc, e.done_cyc);
          if (!e.wr) check("read_data", e.owner_d ? data_out_d : data_out_i, e.data);
        end
      end
    end
  end

  task automatic drive_idle();
    req_i = 1'b0; req_d = 1'b0; wr_d = 1'b0;
    addr_i = '0; addr_d = '0; data_in_d = '0;
  endtask

  task automatic wait_done(input bit port_d, output int c);
    c = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (port_d ? done_d : done_i) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail_event(port_d ? "timeout_done_d" : "timeout_done_i");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    sb.delete();
    stall_left = 0; acc_valid = 1'b0; strobe_cycles = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  {done_i, done_d}, 2'b00);
    check({tag, "_strb"},  {mem_rd, mem_wr}, 2'b00);
    check({tag, "_bus"},   {mem_addr, mem_data_in}, 32'h0);
    check({tag, "_dout"},  {data_out_i, data_out_d}, 32'h0);
    check({tag, "_gcnt"},  {grant_cnt_i, grant_cnt_d}, 32'h0);
    check({tag, "_scnt"},  stall_cnt, 16'h0);
  endtask

  // One transaction from IDLE; request fields are scrambled once granted.
  task automatic run_vec(input vec_t v);
    int c;
    @(negedge clk);
    stall_left = v.stalls;
    if (v.owner_d) begin
      req_d = 1'b1; wr_d = v.wr; addr_d = v.addr; data_in_d = v.wdata;
    end else begin
      req_i = 1'b1; addr_i = v.addr;
    end
    push(v.owner_d, v.wr, v.addr, v.wdata, v.stalls, v.exp_d & {16{v.owner_d}} | v.exp_i & {16{!v.owner_d}},
         cyc + MEM_LAT + 2 + v.stalls);
    @(negedge clk);
    addr_d = ~v.addr; data_in_d = ~v.wdata; addr_i = ~v.addr; wr_d = ~v.wr;
    wait_done(v.owner_d, c);
    drive_idle();
    check("vec_dout_i", data_out_i, v.exp_i);
    check("vec_dout_d", data_out_d, v.exp_d);
  endtask

  vec_t vecs[5];

  initial begin
    int t, c, cd, ci;
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h0000, 16'hBEEF};  // D read
    vecs[1] = '{1'b1, 1'b1, 16'h0022, 16'h1234, 2, 16'h0000, 16'hBEEF};  // D write, 2 stalls
    vecs[2] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 0, 16'hCAFE, 16'hBEEF};  // I read
    vecs[3] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 1, 16'h5A1A, 16'hBEEF};  // I read, 1 stall
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 16'h5A1A, 16'hA5A5};  // D read, top address

    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    check_cleared("reset");

    foreach (vecs[i]) run_vec(vecs[i]);
    check("tbl_grant_d", grant_cnt_d, 16'd3);
    check("tbl_grant_i", grant_cnt_i, 16'd2);
    check("tbl_stall",   stall_cnt,   16'd3);

    // Starvation: I held, D continuously requesting -> three D grants, then I.
    @(negedge clk);
    t = cyc;
    req_i = 1'b1; addr_i = 16'h0100;
    req_d = 1'b1; wr_d = 1'b0; addr_d = 16'h0A00;
    push(1'b1, 1'b0, 16'h0A00, 16'h0, 0, 16'h505A, t + 6);
    push(1'b1, 1'b0, 16'h0A00, 16'h0, 0, 16'h505A, t + 13);
    push(1'b1, 1'b0, 16'h0A00, 16'h0, 0, 16'h505A, t + 20);
    push(1'b0, 1'b0, 16'h0100, 16'h0, 0, 16'hCAFE, t + 27);
    for (int k = 0; k < 3; k++) wait_done(1'b1, c);
    wait_done(1'b0, c);
    drive_idle();
    check("starve_dout_i", data_out_i, 16'hCAFE);
    check("starve_grant_d", grant_cnt_d, 16'd6);
    check("starve_grant_i", grant_cnt_i, 16'd3);

    // Simultaneous requests with the starvation count back at zero: D first, I 7 cycles later.
    @(negedge clk);
    t = cyc;
    req_i = 1'b1; addr_i = 16'h0200;
    req_d = 1'b1; wr_d = 1'b0; addr_d = 16'h0300;
    push(1'b1, 1'b0, 16'h0300, 16'h0, 0, 16'h595A, t + 6);
    push(1'b0, 1'b0, 16'h0200, 16'h0, 0, 16'h585A, t + 13);
    wait_done(1'b1, cd);
    req_d = 1'b0;
    wait_done(1'b0, ci);
    drive_idle();
    check("simul_spacing", ci - cd, 7);

    // Reset in the middle of WAIT abandons the transaction silently.
    @(negedge clk);
    req_d = 1'b1; wr_d = 1'b0; addr_d = 16'h0010;
    push(1'b1, 1'b0, 16'h0010, 16'h0, 0, 16'hBEEF, cyc + 6);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    do_reset();
    check_cleared("midrst");
    repeat (4) @(negedge clk);
    check("midrst_idle", busy, 1'b0);
    run_vec('{1'b0, 1'b0, 16'h0100, 16'h0000, 0, 16'hCAFE, 16'h0000});
    check("post_rst_grant_i", grant_cnt_i, 16'd1);

    // Saturation of the 4-bit grant counter after 17 D grants.
    do_reset();
    @(negedge clk);
    t = cyc;
    req_d = 1'b1; wr_d = 1'b0; addr_d = 16'h0005;
    for (int k = 0; k < 17; k++) push(1'b1, 1'b0, 16'h0005, 16'h0, 0, 16'h5A5F, t + 6 + 7 * k);
    for (int k = 0; k < 17; k++) wait_done(1'b1, c);
    drive_idle();
    check("sat_grant_d_wide", grant_cnt_d, 16'd17);
    check("sat_grant_d_4b",   s_grant_cnt_d, 4'hF);
    check("sat_grant_i_4b",   s_grant_cnt_i, 4'h0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache miss path (port I) and the data-cache miss/writeback path (port D) of the pipelined processor.
- Accepts one outstanding transaction at a time and sequences it through issue, stall-retry and fixed-latency wait.
- Returns read data and a one-cycle done pulse to the owning requester.
- Priority: D over I, with a starvation guard for I. Keeps saturating grant and stall statistics.

Parameters:
- MEM_LAT, 4, cycles from accepted issue to read data valid on mem_data_out (≥1).
- STARVE_MAX, 3, consecutive D grants while I waits before I is forced ahead (≥1).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  I-port request; held until done_i
- addr_i  in  16  I-port word address
- done_i  out  1  one-cycle completion pulse, I port
- data_out_i  out  16  read data, I port
- req_d  in  1  D-port request; held until done_d
- wr_d  in  1  D-port write (1) / read (0)
- addr_d  in  16  D-port word address
- data_in_d  in  16  D-port write data
- done_d  out  1  one-cycle completion pulse, D port
- data_out_d  out  16  read data, D port
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data
- mem_stall  in  1  memory cannot accept strobe this cycle (bank busy)
- busy  out  1  state != IDLE
- grant_cnt_i  out  CNT_W  saturating count of I grants
- grant_cnt_d  out  CNT_W  saturating count of D grants
- stall_cnt  out  CNT_W  saturating count of ISSUE cycles with mem_stall=1

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE; all outputs 0, including data_out_*, counters and starve_cnt. A reset asserted mid-transaction abandons the transaction with no done pulse.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate on req_i/req_d.
  - Winner is D if req_d=1, unless req_i=1 and starve_cnt==STARVE_MAX, in which case I wins.
  - On grant, register owner, address, write flag (forced 0 for I) and write data; go to ISSUE.
  - Grant counter for the winner increments (saturates at all-ones).
  - starve_cnt: on a D grant with req_i=1, starve_cnt+1 (saturating at STARVE_MAX). On a D grant with req_i=0, or on any I grant, starve_cnt=0.
  - No request: stay in IDLE.
- ISSUE: drive mem_rd=~wr or mem_wr=wr, mem_addr, and mem_data_in (write data; 0 for reads).
  - mem_stall=1: stay in ISSUE with strobes held and stall_cnt+1 (saturating).
  - mem_stall=0: issue accepted; load wait counter=MEM_LAT; go to WAIT.
- WAIT: strobes 0. Counter decrements each cycle.
  - In the cycle counter==1, capture mem_data_out into the owner's data_out register (reads only; writes leave data_out unchanged), then go to DONE.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- DONE: done_<owner>=1 for exactly this cycle; go to IDLE. Requester drops req on the following edge. A req still high in IDLE is a new transaction.
- Latency: request first seen in IDLE at cycle t with no stall → ISSUE at t+1, done at t+MEM_LAT+2 (default t+6). Each stall cycle adds 1.
- Minimum spacing between grants: IDLE→…→DONE→IDLE. There are no back-to-back grants without an IDLE cycle.
- Request fields are sampled only at grant. Changes afterwards are ignored. A req dropped before done still completes and still pulses done.
- mem_addr and mem_data_in are 0 outside ISSUE. data_out_* hold their value until overwritten by a later read.
- done_i and done_d are never high together. mem_rd and mem_wr are never high together.

Test Plan:
- Single D read: req_d=1, wr_d=0, addr_d=0x0010, mem returns 0xBEEF in the capture cycle → mem_rd=1 at t+1 with mem_addr=0x0010; done_d at t+6; data_out_d=0xBEEF; grant_cnt_d=1.
- D write with 2 stall cycles: wr_d=1, addr_d=0x0022, data_in_d=0x1234, mem_stall=1 for the first 2 ISSUE cycles → mem_wr held 3 cycles with mem_data_in=0x1234; done_d at t+8; stall_cnt=2; data_out_d unchanged.
- Simultaneous requests: req_i and req_d both high in IDLE, starve_cnt=0 → D granted first; I granted in the next IDLE; done_d precedes done_i by 7 cycles.
- Starvation: req_i held, req_d re-asserted every IDLE → exactly 3 D grants, then an I grant (addr_i=0x0100, data 0xCAFE, data_out_i=0xCAFE); starve_cnt returns to 0.
- Reset mid-WAIT: rst=1 for 1 cycle during WAIT → state IDLE, busy=0, no done pulse, counters=0; a new req_i after reset completes normally in 6 cycles.
- Counter saturation (CNT_W=4): 17 D grants → grant_cnt_d=0xF.
